// File: rtl/voice_scheduler.sv
// Time-multiplexed voice mixer: one shared sine unit and multiplier serve all voices each frame.
// Optional macro VOICE_SCHEDULER_SATURATE_EN clamps the mixed sample instead of wrapping it.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SINE_LAT   = 2,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_SampleStrobe,
    input  logic               i_CfgWrite,
    input  logic [3:0]         i_CfgVoice,
    input  logic [15:0]        i_CfgFreq,
    input  logic signed [17:0] i_CfgLevel,
    output logic [12:0]        o_SineArg,
    input  logic signed [17:0] i_SineResult,
    output logic signed [17:0] o_MulA,
    output logic signed [17:0] o_MulB,
    input  logic signed [17:0] i_MulResult,
    output logic signed [17:0] o_Sample,
    output logic               o_SampleValid,
    output logic               o_Busy,
    output logic               o_Overrun
);

    localparam int unsigned VIDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned PHASE_W = 16;
    localparam int unsigned DATA_W  = 18;
    localparam int unsigned ACC_W   = 22;
    localparam int unsigned ARG_W   = 13;

    typedef enum logic [2:0] {S_IDLE, S_SINE, S_MUL, S_ACC, S_DONE} state_t;

    state_t                     state_q, nxt_state;
    logic [VIDX_W-1:0]          idx_q, nxt_idx;
    logic [WAIT_W-1:0]          wait_q, nxt_wait;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [DATA_W-1:0]   sine_q;
    logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]         freq_q  [NUM_VOICES];
    logic signed [DATA_W-1:0]   level_q [NUM_VOICES];

    logic                       clr_acc, add_acc, capture, done, overrun_set;
    logic [ARG_W-1:0]           sine_arg_d;
    logic signed [DATA_W-1:0]   mul_a_d, mul_b_d, sample_d;
    logic                       cfg_hit;
    logic [VIDX_W-1:0]          cfg_idx;

    assign cfg_hit = ({1'b0, i_CfgVoice} < 5'(NUM_VOICES));
    assign cfg_idx = VIDX_W'(i_CfgVoice);

    // Next-state, sequencing strobes and the operand values for the coming cycle
    always_comb begin
        nxt_state   = state_q;
        nxt_idx     = idx_q;
        nxt_wait    = wait_q;
        clr_acc     = 1'b0;
        add_acc     = 1'b0;
        capture     = 1'b0;
        done        = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_SampleStrobe) begin
                    nxt_state = S_SINE;
                    nxt_idx   = '0;
                    nxt_wait  = '0;
                    clr_acc   = 1'b1;
                end
            end
            S_SINE: begin
                if (wait_q == WAIT_W'(SINE_LAT - 1)) begin
                    capture   = 1'b1;
                    nxt_state = S_MUL;
                    nxt_wait  = '0;
                end else begin
                    nxt_wait = wait_q + WAIT_W'(1);
                end
            end
            S_MUL: begin
                if (wait_q == WAIT_W'(MUL_LAT - 1)) begin
                    nxt_state = S_ACC;
                    nxt_wait  = '0;
                end else begin
                    nxt_wait = wait_q + WAIT_W'(1);
                end
            end
            S_ACC: begin
                add_acc = 1'b1;
                if (idx_q == VIDX_W'(NUM_VOICES - 1)) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_idx   = idx_q + VIDX_W'(1);
                    nxt_state = S_SINE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
        if (i_SampleStrobe && (state_q != S_IDLE)) overrun_set = 1'b1;

        sine_arg_d = '0;
        mul_a_d    = '0;
        mul_b_d    = '0;
        if (nxt_state == S_SINE) sine_arg_d = phase_q[nxt_idx][PHASE_W-1:3];
        if (nxt_state == S_MUL) begin
            mul_a_d = capture ? i_SineResult : sine_q;
            mul_b_d = level_q[nxt_idx];
        end
    end

    // Final mix: clamp or wrap the wide accumulator into the sample width
`ifdef VOICE_SCHEDULER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = 22'sd131071;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -22'sd131072;
    always_comb begin
        sample_d = acc_q[DATA_W-1:0];
        if (acc_q > SAT_MAX)      sample_d = 18'sd131071;
        else if (acc_q < SAT_MIN) sample_d = -18'sd131072;
    end
`else
    assign sample_d = acc_q[DATA_W-1:0];
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wait_q        <= '0;
            acc_q         <= '0;
            sine_q        <= '0;
            o_SineArg     <= '0;
            o_MulA        <= '0;
            o_MulB        <= '0;
            o_Sample      <= '0;
            o_SampleValid <= 1'b0;
            o_Busy        <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            state_q       <= nxt_state;
            idx_q         <= nxt_idx;
            wait_q        <= nxt_wait;
            o_SineArg     <= sine_arg_d;
            o_MulA        <= mul_a_d;
            o_MulB        <= mul_b_d;
            o_Busy        <= (nxt_state != S_IDLE);
            o_SampleValid <= done;
            o_Overrun     <= o_Overrun | overrun_set;
            if (capture) sine_q <= i_SineResult;
            if (clr_acc)      acc_q <= '0;
            else if (add_acc) acc_q <= acc_q + {{(ACC_W-DATA_W){i_MulResult[DATA_W-1]}}, i_MulResult};
            if (done) o_Sample <= sample_d;
        end
    end

    // Voice registers; the phase steps once per frame as its sine lookup completes
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                freq_q[i]  <= '0;
                level_q[i] <= '0;
            end
        end else begin
            if (capture) phase_q[idx_q] <= phase_q[idx_q] + freq_q[idx_q];
            if (i_CfgWrite && cfg_hit) begin
                freq_q[cfg_idx]  <= i_CfgFreq;
                level_q[cfg_idx] <= i_CfgLevel;
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized self-checking bench for voice_scheduler with stub sine unit and multiplier
// and a frame-level reference mixer.
module tb_voice_scheduler;

    localparam int NV    = 8;
    localparam int LATCY = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strobe = 1'b0;
    logic cfg_wr = 1'b0;
    logic [3:0] cfg_voice = '0;
    logic [15:0] cfg_freq = '0;
    logic signed [17:0] cfg_level = '0;
    logic [12:0] sine_arg;
    logic signed [17:0] sine_result;
    logic signed [17:0] mul_a, mul_b;
    logic signed [17:0] mul_result = '0;
    logic signed [17:0] sample;
    logic sample_valid, busy, overrun;

    int sine_mode  = 0;
    int sine_const = 65536;

    int checks   = 0;
    int failures = 0;

    int m_phase [NV];
    int m_freq  [NV];
    int m_level [NV];

    voice_scheduler dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_SampleStrobe (strobe),
        .i_CfgWrite     (cfg_wr),
        .i_CfgVoice     (cfg_voice),
        .i_CfgFreq      (cfg_freq),
        .i_CfgLevel     (cfg_level),
        .o_SineArg      (sine_arg),
        .i_SineResult   (sine_result),
        .o_MulA         (mul_a),
        .o_MulB         (mul_b),
        .i_MulResult    (mul_result),
        .o_Sample       (sample),
        .o_SampleValid  (sample_valid),
        .o_Busy         (busy),
        .o_Overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic signed [17:0] sine_fn(input logic [12:0] a, input int mode, input int k);
        logic [17:0] t;
        if (mode == 0) t = 18'(k);
        else           t = 18'(int'(a) * 97 + 12345);
        return $signed(t);
    endfunction

    function automatic logic signed [17:0] mul_fn(input logic signed [17:0] a, input logic signed [17:0] b);
        logic signed [35:0] p;
        p = a * b;
        return 18'(p >>> 17);
    endfunction

    assign sine_result = sine_fn(sine_arg, sine_mode, sine_const);
    always @(posedge clk) mul_result <= mul_fn(mul_a, mul_b);

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_freq[v]  = 0;
            m_level[v] = 0;
        end
    endtask

    // One frame of the mixer computed directly from the voice rules
    task automatic model_frame(output int es, output int ea);
        int acc, arg;
        logic signed [17:0] s, p;
        acc = 0;
        ea  = 0;
        for (int v = 0; v < NV; v++) begin
            arg = (m_phase[v] >> 3) & 'h1FFF;
            if (v == 0) ea = arg;
            s = sine_fn(13'(arg), sine_mode, sine_const);
            p = mul_fn(s, 18'(m_level[v]));
            acc += int'(p);
            m_phase[v] = (m_phase[v] + m_freq[v]) & 'hFFFF;
        end
`ifdef VOICE_SCHEDULER_SATURATE_EN
        if (acc > 131071)       es = 131071;
        else if (acc < -131072) es = -131072;
        else                    es = acc;
`else
        es = acc & 'h3FFFF;
        if (es >= 131072) es -= 262144;
`endif
    endtask

    task automatic cfg_write(input int v, input int f, input int l);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_voice = 4'(v); cfg_freq = 16'(f); cfg_level = 18'(l);
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        if (v < NV) begin
            m_freq[v]  = f & 'hFFFF;
            m_level[v] = l;
        end
    endtask

    // Strobe, then observe 41 cycles; cycle k is sampled on the negedge after the k-th edge
    task automatic run_frame(input int stray_at, output int busy_cnt, output int valid_cnt,
                             output int valid_cyc, output int smp, output int arg0);
        busy_cnt = 0; valid_cnt = 0; valid_cyc = -1; smp = 0; arg0 = -1;
        @(posedge clk); #1;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            strobe = (k + 1 == stray_at);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (sample_valid) begin
                valid_cnt++;
                valid_cyc = k;
                smp = int'(sample);
            end
            if (k == 0) arg0 = int'(sine_arg);
            @(posedge clk); #1;
        end
        strobe = 1'b0;
    endtask

    task automatic frame_check(input string tag, input int stray_at);
        int bc, vc, vy, sm, a0, es, ea;
        model_frame(es, ea);
        run_frame(stray_at, bc, vc, vy, sm, a0);
        chk({tag, "_busy"}, bc, LATCY);
        chk({tag, "_nvalid"}, vc, 1);
        chk({tag, "_vcycle"}, vy, LATCY);
        chk({tag, "_sample"}, sm, es);
        chk({tag, "_arg0"}, a0, ea);
    endtask

    initial begin
        int vc;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_sinearg", int'(sine_arg), 0);
        chk("rst_mula", int'(mul_a), 0);
        chk("rst_mulb", int'(mul_b), 0);
        rst_n = 1'b1;

        // All levels zero
        sine_mode = 0; sine_const = 65536;
        frame_check("zero", -1);
        chk("zero_overrun", int'(overrun), 0);

        // Single voice with stub sine, phase stepping 8 per frame
        cfg_write(0, 'h0008, 131071);
        frame_check("v0_f1", -1);
        frame_check("v0_f2", -1);

        // Eight equal products overflow the sample range
        sine_const = -131072;
        for (int v = 0; v < NV; v++) cfg_write(v, m_freq[v], -65536);
        frame_check("sum8", -1);
`ifdef VOICE_SCHEDULER_SATURATE_EN
        chk("sum8_const", int'(sample), 131071);
`else
        chk("sum8_const", int'(sample), 0);
`endif

        // Stray strobe mid-frame is dropped and latches overrun
        frame_check("stray", 10);
        chk("stray_overrun", int'(overrun), 1);
        frame_check("sticky", -1);
        chk("sticky_overrun", int'(overrun), 1);

        // Phase wraparound
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        sine_const = 65536;
        cfg_write(0, 'h0004, 131071);
        frame_check("wrap_a", -1);
        cfg_write(0, 'hFFF8, 131071);
        frame_check("wrap_b", -1);
        frame_check("wrap_c", -1);
        chk("wrap_arg", int'(sine_arg), 0);

        // Randomized voices and a position-dependent sine
        sine_mode = 1;
        for (int f = 0; f < 6; f++) begin
            for (int v = 0; v < NV; v++)
                cfg_write(v, int'($urandom_range(65535)), int'($urandom_range(262142)) - 131071);
            frame_check($sformatf("rnd%0d", f), -1);
        end

        // Reset during a frame aborts it
        @(posedge clk); #1;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sample", int'(sample), 0);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_sinearg", int'(sine_arg), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        vc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sample_valid) vc++;
        end
        chk("midrst_novalid", vc, 0);

        // Out-of-range voice index must not touch any voice
        sine_mode = 0; sine_const = 65536;
        cfg_write(12, 'h0100, 131071);
        cfg_write(15, 'h0100, -131071);
        frame_check("oor", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_VOICES, default 8, meaning the number of voices processed per frame (2..16).
REQ-002 The module SHALL have parameter SINE_LAT, default 2, meaning the sine_function cycles from argument to result.
REQ-003 The module SHALL have parameter MUL_LAT, default 1, meaning the multiplier cycles from operands to result.
REQ-004 The module SHALL have port i_Clock, input, 1 bit, the sole clock; all logic on its rising edge.
REQ-005 The module SHALL have port i_Reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The module SHALL have port i_SampleStrobe, input, 1 bit, a one-cycle pulse that starts a frame.
REQ-007 The module SHALL have ports i_CfgWrite (1 bit), i_CfgVoice (4 bits), i_CfgFreq (16 bits) and i_CfgLevel (signed 18 bits), all inputs, forming the voice register write port.
REQ-008 The module SHALL have port o_SineArg, output, 13 bits, driving the shared sine unit argument.
REQ-009 The module SHALL have port i_SineResult, input, signed 18 bits, the sine unit result.
REQ-010 The module SHALL have ports o_MulA and o_MulB, outputs, signed 18 bits each, driving the shared multiplier operands.
REQ-011 The module SHALL have port i_MulResult, input, signed 18 bits, the multiplier result.
REQ-012 The module SHALL have ports o_Sample (signed 18 bits), o_SampleValid (1 bit), o_Busy (1 bit) and o_Overrun (1 bit), all outputs.

Function
REQ-013 The module SHALL hold per voice a 16-bit phase, a 16-bit frequency increment and an 18-bit signed level.
REQ-014 When i_CfgWrite=1 and i_CfgVoice<NUM_VOICES, the module SHALL update that voice's freq and level on the clock edge; out-of-range indices SHALL be ignored; writes SHALL be accepted while busy.
REQ-015 The FSM SHALL have states IDLE, SINE, MUL, ACC and DONE, with a voice index counter and a wait counter.
REQ-016 In IDLE, a strobe SHALL clear the accumulator, set voice index 0 and enter SINE; o_Busy SHALL be 1 in every state except IDLE.
REQ-017 In SINE, o_SineArg SHALL equal phase[15:3] of the current voice, held for SINE_LAT cycles; i_SineResult SHALL be captured on the last cycle; the phase SHALL advance by freq modulo 2^16 exactly once per frame.
REQ-018 In MUL, o_MulA SHALL equal the captured sine and o_MulB SHALL equal the level, held for MUL_LAT cycles; then ACC SHALL add i_MulResult, sign-extended to 22 bits, into the accumulator in 1 cycle.
REQ-019 After ACC, the FSM SHALL go to SINE for the next voice, or to DONE after voice NUM_VOICES-1.
REQ-020 In DONE, o_Sample SHALL update from the accumulator (see REQ-027), o_SampleValid SHALL pulse for exactly 1 cycle, and the FSM SHALL return to IDLE.
REQ-021 Latency from strobe to o_SampleValid SHALL be NUM_VOICES*(SINE_LAT+MUL_LAT+1)+1 cycles, i.e. 33 cycles at defaults.
REQ-022 o_Sample SHALL hold its value between frames.
REQ-023 A strobe arriving while not IDLE, including in DONE, SHALL be dropped and SHALL set o_Overrun, which is sticky until reset.
REQ-024 Outside SINE and MUL, o_SineArg, o_MulA and o_MulB SHALL be 0.

Reset
REQ-025 When i_Reset_n=0, the module SHALL asynchronously force state IDLE, all counters, phases, freqs, levels and the accumulator to 0, and o_Sample=0, o_SampleValid=0, o_Busy=0 and o_Overrun=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame, with no o_SampleValid pulse afterward until a new strobe.

Configuration
REQ-027 With macro VOICE_SCHEDULER_SATURATE_EN defined, o_Sample SHALL be the accumulator clamped to [-131072, 131071]; without it, o_Sample SHALL be accumulator[17:0] (two's-complement wrap).

Verification
REQ-028 The bench SHALL cover: reset, then a strobe with all levels 0 -> o_Busy=1 for 33 cycles, o_SampleValid pulse at cycle 33, o_Sample=0.
REQ-029 The bench SHALL cover: voice 0 with freq=0x0008 and level=131071, a stub sine returning 65536, and a stub multiplier computing (A*B)>>>17 -> o_Sample=65535; o_SineArg=0 on frame 1 and 1 on frame 2.
REQ-030 The bench SHALL cover: all 8 voices with a product of 65536 -> sum 524288; with the macro, o_Sample=131071; without it, o_Sample=0.
REQ-031 The bench SHALL cover: a second strobe at cycle 10 of a frame -> ignored, o_Overrun=1, exactly one valid pulse at cycle 33.
REQ-032 The bench SHALL cover: voice 0 with freq=0xFFF8 starting from phase 0x0004 -> phase wraps to 0xFFFC with no error.
REQ-033 The bench SHALL cover: i_Reset_n low at cycle 15 of a frame -> outputs 0 immediately and no valid pulse; a write to i_CfgVoice=12 -> no register change.
